// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding instruction fetch stage.
// Fetches the word at pc and holds it for decode until the downstream stage
// accepts it. On acceptance it computes the next pc from the redirect inputs.
// Optional build macro IFETCH_TIMEOUT_EN adds an ack-wait watchdog that raises
// a sticky fetch_err and reissues the fetch after a one-cycle request gap.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [3:0]  TIMEOUT_CYC = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] rs_data,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [15:0] retired,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_VALID,
        ST_HALT
    } state_t;

    localparam logic [5:0] OPC_HALT = 6'b111111;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [15:0] retired_q, retired_d;
    logic [31:0] next_pc;
    logic        req_gap;

    assign pc_plus4    = pc_q + 32'd4;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign retired     = retired_q;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_VALID);
    assign halted      = (state_q == ST_HALT);
    // The request is masked during reset so an in-flight fetch is abandoned.
    assign imem_req    = (state_q == ST_REQ) && !rst && !req_gap;

    // Redirect target for the held instruction: register jump, then absolute jump, then taken branch.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg) begin
            next_pc = {rs_data[31:2], 2'b00};
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        end
    end

    // Fetch FSM next-state logic: capture on ack, release on no-stall, park on halt opcode.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        unique case (state_q)
            ST_REQ: begin
                if (imem_ack && !req_gap) begin
                    instr_d = imem_rdata;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (!stall) begin
                    retired_d = retired_q + 16'd1;
                    if (instr_q[31:26] == OPC_HALT) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // Fetch state registers with synchronous reset; reset overrides a same-cycle ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

`ifdef IFETCH_TIMEOUT_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       gap_q, gap_d;
    logic       fetch_err_q, fetch_err_d;

    assign req_gap   = gap_q;
    assign fetch_err = fetch_err_q;

    // Watchdog: count unacknowledged request cycles; on expiry flag the error and drop the request for one cycle.
    always_comb begin
        wait_cnt_d  = 4'd0;
        gap_d       = 1'b0;
        fetch_err_d = fetch_err_q;
        if ((state_q == ST_REQ) && !gap_q && !imem_ack) begin
            if ((wait_cnt_q + 4'd1) == TIMEOUT_CYC) begin
                gap_d       = 1'b1;
                fetch_err_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
        end
    end

    // Watchdog registers; fetch_err stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q  <= 4'd0;
            gap_q       <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            gap_q       <= gap_d;
            fetch_err_q <= fetch_err_d;
        end
    end
`else
    logic unused_ok;

    assign req_gap   = 1'b0;
    assign fetch_err = 1'b0;
    assign unused_ok = ^{TIMEOUT_CYC, rs_data[1:0]};
`endif

endmodule
